// File: rtl/if_stage_if.sv
// ============================================================================
//  Module      : if_stage_if
//  Description : Bundle of the fetch-stage signals: program-memory
//                request/response, decode-side hazard/redirect inputs,
//                registered decode outputs and performance counters.
//                master = fetch stage, slave = its environment.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface if_stage_if;
    // Program-memory side
    logic                   imem_req_o;
    logic [`DATA_WIDTH-1:0] imem_addr_o;
    logic                   imem_rvalid_i;
    logic [`DATA_WIDTH-1:0] imem_rdata_i;

    // Control from later stages
    logic                   stall_i;
    logic                   stall_general_i;
    logic                   brj_i;
    logic [`DATA_WIDTH-1:0] brj_pc_i;

    // Decode register
    logic [`DATA_WIDTH-1:0] d_instruction_o;
    logic [`DATA_WIDTH-1:0] d_pc_o;
    logic [`DATA_WIDTH-1:0] d_pc4_o;
    logic                   d_valid_o;

    // Performance counters
    logic [31:0]            perf_fetched_o;
    logic [31:0]            perf_flushed_o;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_rvalid_i, imem_rdata_i,
        input  stall_i, stall_general_i, brj_i, brj_pc_i,
        output d_instruction_o, d_pc_o, d_pc4_o, d_valid_o,
        output perf_fetched_o, perf_flushed_o
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_rvalid_i, imem_rdata_i,
        output stall_i, stall_general_i, brj_i, brj_pc_i,
        input  d_instruction_o, d_pc_o, d_pc4_o, d_valid_o,
        input  perf_fetched_o, perf_flushed_o
    );
endinterface

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
//  Module      : if_stage
//  Description : Instruction-fetch stage. Owns the fetch PC, issues at most
//                one outstanding program-memory request, buffers responses in
//                a small prefetch FIFO and presents a registered
//                {instruction, pc, pc+4} to decode. Hazard/general stalls
//                freeze the decode register; branch/jump redirects flush the
//                FIFO and discard the in-flight wrong-path word.
//                Optional feature macro: IF_PERF_CNT_EN (fetched/flushed
//                counters; outputs tied to zero when undefined).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module if_stage #(
    parameter logic [`DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                     FIFO_DEPTH = 2,
    parameter logic [`DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input wire         clk,
    input wire         rst_n,
    if_stage_if.master bus
);

    localparam int c_dw    = `DATA_WIDTH;
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    localparam logic [c_cnt_w:0]   c_depth      = (c_cnt_w+1)'(FIFO_DEPTH);
    localparam logic [c_ptr_w-1:0] c_ptr_one    = 1;
    localparam logic [c_dw-1:0]    c_four       = 4;
    localparam logic [c_dw-1:0]    c_align_mask = 3;

    // Memory-request tracker: nothing in flight, one in flight to keep,
    // or one in flight that belongs to a squashed path.
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_drop = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;

    logic [c_dw-1:0]    r_fetch_pc;
    logic [c_dw-1:0]    r_req_addr;

    logic [c_dw-1:0]    r_fifo_instr [FIFO_DEPTH];
    logic [c_dw-1:0]    r_fifo_pc    [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic [c_dw-1:0]    r_d_instr;
    logic [c_dw-1:0]    r_d_pc;
    logic [c_dw-1:0]    r_d_pc4;
    logic               r_d_valid;

    logic               w_hold;
    logic               w_redirect;
    logic               w_fifo_nonempty;
    logic               w_pop;
    logic [c_dw-1:0]    w_target;

    logic               w_outstanding;
    logic               w_discard;
    logic               w_resp;
    logic               w_push;
    logic               w_drop;
    logic [c_cnt_w:0]   w_occupancy;
    logic [c_cnt_w:0]   w_limit;
    logic               w_req;

    assign w_hold          = bus.stall_i | bus.stall_general_i;
    assign w_redirect      = bus.brj_i & ~w_hold;
    assign w_fifo_nonempty = (r_count != '0);
    assign w_pop           = ~w_hold & ~w_redirect & w_fifo_nonempty;
    assign w_target        = bus.brj_pc_i & ~c_align_mask;

    // Request tracker state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Request tracker next state: a redirect turns a still-pending request
    // into one to be dropped; a response retires it unless re-issued.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_req) begin
                    w_state_next = c_st_busy;
                end
            end
            c_st_busy, c_st_drop: begin
                if (w_redirect) begin
                    w_state_next = bus.imem_rvalid_i ? c_st_idle : c_st_drop;
                end else if (bus.imem_rvalid_i) begin
                    w_state_next = w_req ? c_st_busy : c_st_idle;
                end
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    // Request tracker outputs: response routing and the issue decision.
    // A response with nothing outstanding is ignored entirely.
    always_comb begin
        w_outstanding = (r_state != c_st_idle);
        w_discard     = (r_state == c_st_drop);
        w_resp        = bus.imem_rvalid_i & w_outstanding;
        w_push        = w_resp & ~w_discard & ~w_redirect;
        w_drop        = w_resp & (w_discard | w_redirect);
        // Occupancy counts the in-flight word as already holding a slot, so
        // a push can never hit a full FIFO.
        w_occupancy   = {1'b0, r_count} + {{c_cnt_w{1'b0}}, w_outstanding};
        w_limit       = c_depth + {{c_cnt_w{1'b0}}, w_pop};
        w_req         = ~w_redirect
                      & (~w_outstanding | bus.imem_rvalid_i)
                      & (w_occupancy < w_limit);
    end

    assign bus.imem_req_o  = w_req;
    assign bus.imem_addr_o = r_fetch_pc;

    // Fetch PC: jump to the word-aligned target on redirect, else advance
    // on every issued request and remember the address for the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_req_addr <= '0;
        end else if (w_redirect) begin
            r_fetch_pc <= w_target;
        end else if (w_req) begin
            r_fetch_pc <= r_fetch_pc + c_four;
            r_req_addr <= r_fetch_pc;
        end
    end

    // FIFO storage: written on push, no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_instr[r_wr_ptr] <= bus.imem_rdata_i;
            r_fifo_pc[r_wr_ptr]    <= r_req_addr;
        end
    end

    // FIFO pointers and count: cleared on redirect, else push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_redirect) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            r_count <= r_count + {{(c_cnt_w-1){1'b0}}, w_push}
                               - {{(c_cnt_w-1){1'b0}}, w_pop};
        end
    end

    // Decode register: frozen under hold; bubble on redirect or empty FIFO
    // (bubbles keep the last pc/pc4), otherwise load the FIFO head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d_instr <= NOP_INSTR;
            r_d_pc    <= '0;
            r_d_pc4   <= '0;
            r_d_valid <= 1'b0;
        end else if (!w_hold) begin
            if (w_pop) begin
                r_d_instr <= r_fifo_instr[r_rd_ptr];
                r_d_pc    <= r_fifo_pc[r_rd_ptr];
                r_d_pc4   <= r_fifo_pc[r_rd_ptr] + c_four;
                r_d_valid <= 1'b1;
            end else begin
                r_d_instr <= NOP_INSTR;
                r_d_valid <= 1'b0;
            end
        end
    end

    assign bus.d_instruction_o = r_d_instr;
    assign bus.d_pc_o          = r_d_pc;
    assign bus.d_pc4_o         = r_d_pc4;
    assign bus.d_valid_o       = r_d_valid;

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_flushed;
    logic [31:0] w_flush_inc;

    assign w_flush_inc = (w_redirect ? 32'(r_count) : 32'd0) + {31'd0, w_drop};

    // Wrapping counters of valid decode loads and of squashed words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetched <= '0;
            r_perf_flushed <= '0;
        end else begin
            if (w_pop) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            r_perf_flushed <= r_perf_flushed + w_flush_inc;
        end
    end

    assign bus.perf_fetched_o = r_perf_fetched;
    assign bus.perf_flushed_o = r_perf_flushed;
`else
    assign bus.perf_fetched_o = '0;
    assign bus.perf_flushed_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
//  Module      : tb_if_stage
//  Description : Self-checking bench for if_stage with a behavioural
//                program memory that returns the request address as data.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;
    int   lat;

    if_stage_if bus();

    if_stage #(
        .RESET_PC   (32'h0000_0100),
        .FIFO_DEPTH (2),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Program memory: one request in flight, response 'lat' cycles later,
    // data = address. Requests are ignored while reset is asserted, but a
    // request already in flight still returns.
    initial begin : g_mem
        bit          pend;
        int          wt;
        logic [31:0] paddr;
        logic        r;
        logic [31:0] a;
        pend = 0; wt = 0; paddr = '0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk);
            r = bus.imem_req_o;
            a = bus.imem_addr_o;
            if (bus.imem_rvalid_i) pend = 0;
            if (r && rst_n) begin
                pend = 1; paddr = a; wt = lat - 1;
            end else if (pend && wt > 0) begin
                wt--;
            end
            #1;
            bus.imem_rvalid_i = pend && (wt == 0);
            bus.imem_rdata_i  = (pend && wt == 0) ? paddr : 32'hDEAD_BEEF;
        end
    end

    // A push into a full FIFO is impossible by construction.
    always @(negedge clk) begin
        if (rst_n) begin
            assert (!(dut.w_push && dut.r_count == 2'd2)) else begin
                n_fail++;
                $display("FAIL push_while_full: count %0d", dut.r_count);
            end
        end
    end

    task automatic drive(input logic s, input logic sg, input logic b, input logic [31:0] bpc);
        bus.stall_i         = s;
        bus.stall_general_i = sg;
        bus.brj_i           = b;
        bus.brj_pc_i        = bpc;
    endtask

    // Leaves time just after the release inside cycle 0.
    task automatic do_reset(input int l);
        rst_n = 1'b0;
        drive(0, 0, 0, 32'h0);
        lat = l;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        stall;
        logic        sg;
        logic        brj;
        logic [31:0] bpc;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic sg, input logic b, input logic [31:0] bpc,
                                input logic rq, input logic [31:0] ad, input logic v,
                                input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] p4);
        vec_t t;
        t.stall = s; t.sg = sg; t.brj = b; t.bpc = bpc; t.req = rq; t.addr = ad;
        t.valid = v; t.pc = pc; t.instr = ins; t.pc4 = p4;
        return t;
    endfunction

    vec_t tbl [23];

    initial begin
        bit found;
        n_cmp = 0; n_fail = 0; lat = 1;
        rst_n = 1'b0;
        drive(0, 0, 0, 32'h0);

        // Cycle-by-cycle expectations after reset with a 1-cycle memory.
        tbl[0]  = mk(0,0,0,32'h0,   1,32'h100, 0,32'h0,  NOP,32'h0);
        tbl[1]  = mk(0,0,0,32'h0,   1,32'h104, 0,32'h0,  NOP,32'h0);
        tbl[2]  = mk(0,0,0,32'h0,   1,32'h108, 0,32'h0,  NOP,32'h0);
        tbl[3]  = mk(0,0,0,32'h0,   1,32'h10C, 1,32'h100,32'h100,32'h104);
        tbl[4]  = mk(0,0,0,32'h0,   1,32'h110, 1,32'h104,32'h104,32'h108);
        tbl[5]  = mk(0,0,0,32'h0,   1,32'h114, 1,32'h108,32'h108,32'h10C);
        tbl[6]  = mk(1,0,0,32'h0,   0,32'h118, 1,32'h10C,32'h10C,32'h110);
        tbl[7]  = mk(1,0,0,32'h0,   0,32'h118, 1,32'h10C,32'h10C,32'h110);
        tbl[8]  = mk(1,0,0,32'h0,   0,32'h118, 1,32'h10C,32'h10C,32'h110);
        tbl[9]  = mk(0,0,0,32'h0,   1,32'h118, 1,32'h10C,32'h10C,32'h110);
        tbl[10] = mk(0,0,0,32'h0,   1,32'h11C, 1,32'h110,32'h110,32'h114);
        tbl[11] = mk(0,0,0,32'h0,   1,32'h120, 1,32'h114,32'h114,32'h118);
        tbl[12] = mk(0,0,0,32'h0,   1,32'h124, 1,32'h118,32'h118,32'h11C);
        tbl[13] = mk(0,1,1,32'h300, 0,32'h128, 1,32'h11C,32'h11C,32'h120);
        tbl[14] = mk(0,0,0,32'h0,   1,32'h128, 1,32'h11C,32'h11C,32'h120);
        tbl[15] = mk(0,0,0,32'h0,   1,32'h12C, 1,32'h120,32'h120,32'h124);
        tbl[16] = mk(0,0,0,32'h0,   1,32'h130, 1,32'h124,32'h124,32'h128);
        tbl[17] = mk(0,0,1,32'h203, 0,32'h134, 1,32'h128,32'h128,32'h12C);
        tbl[18] = mk(0,0,0,32'h0,   1,32'h200, 0,32'h128,NOP,   32'h12C);
        tbl[19] = mk(0,0,0,32'h0,   1,32'h204, 0,32'h128,NOP,   32'h12C);
        tbl[20] = mk(0,0,0,32'h0,   1,32'h208, 0,32'h128,NOP,   32'h12C);
        tbl[21] = mk(0,0,0,32'h0,   1,32'h20C, 1,32'h200,32'h200,32'h204);
        tbl[22] = mk(0,0,0,32'h0,   1,32'h210, 1,32'h204,32'h204,32'h208);

        // Reset values while reset is held
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_instr", bus.d_instruction_o, NOP);
        chk("rst_pc", bus.d_pc_o, 32'h0);
        chk("rst_pc4", bus.d_pc4_o, 32'h0);
        chk("rst_valid", {31'd0, bus.d_valid_o}, 32'd0);
        chk("rst_addr", bus.imem_addr_o, 32'h100);
        chk("rst_perf_fetched", bus.perf_fetched_o, 32'd0);
        chk("rst_perf_flushed", bus.perf_flushed_o, 32'd0);

        // Table-driven stream: start-up latency, hazard stall, ignored
        // redirect under general stall, misaligned redirect target.
        do_reset(1);
        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].stall, tbl[i].sg, tbl[i].brj, tbl[i].bpc);
            @(negedge clk);
            chk($sformatf("t%0d_req", i), {31'd0, bus.imem_req_o}, {31'd0, tbl[i].req});
            chk($sformatf("t%0d_addr", i), bus.imem_addr_o, tbl[i].addr);
            chk($sformatf("t%0d_valid", i), {31'd0, bus.d_valid_o}, {31'd0, tbl[i].valid});
            chk($sformatf("t%0d_pc", i), bus.d_pc_o, tbl[i].pc);
            chk($sformatf("t%0d_instr", i), bus.d_instruction_o, tbl[i].instr);
            chk($sformatf("t%0d_pc4", i), bus.d_pc4_o, tbl[i].pc4);
            if (i == 18) begin
                chk("t18_perf_fetched", bus.perf_fetched_o, PERF ? 32'd11 : 32'd0);
                chk("t18_perf_flushed", bus.perf_flushed_o, PERF ? 32'd2 : 32'd0);
            end
            next_cycle();
        end

        // Redirect with a 3-cycle memory while a request is in flight
        do_reset(3);
        next_cycle();
        drive(0, 0, 1, 32'h200);
        @(negedge clk);
        chk("rd3_req_on_redirect", {31'd0, bus.imem_req_o}, 32'd0);
        next_cycle();
        drive(0, 0, 0, 32'h0);
        found = 0;
        for (int k = 2; k < 14 && !found; k++) begin
            @(negedge clk);
            if (k == 3) begin
                chk("rd3_late_rvalid", {31'd0, bus.imem_rvalid_i}, 32'd1);
                chk("rd3_reissue_req", {31'd0, bus.imem_req_o}, 32'd1);
                chk("rd3_reissue_addr", bus.imem_addr_o, 32'h200);
            end
            if (bus.d_valid_o) begin
                found = 1;
                chk("rd3_first_pc", bus.d_pc_o, 32'h200);
                chk("rd3_first_instr", bus.d_instruction_o, 32'h200);
                chk("rd3_first_cycle", k, 8);
            end else begin
                chk("rd3_bubble_instr", bus.d_instruction_o, NOP);
            end
            next_cycle();
        end
        if (!found) begin
            n_cmp++; n_fail++;
            $display("FAIL rd3_timeout: no valid instruction after redirect, required pc 00000200");
        end
        chk("rd3_perf_flushed", bus.perf_flushed_o, PERF ? 32'd1 : 32'd0);

        // PC wrap from 0xFFFF_FFFC to 0
        do_reset(1);
        drive(0, 0, 1, 32'hFFFF_FFFC);
        next_cycle();
        drive(0, 0, 0, 32'h0);
        @(negedge clk);
        chk("wrap_addr0", bus.imem_addr_o, 32'hFFFF_FFFC);
        next_cycle();
        @(negedge clk);
        chk("wrap_addr1", bus.imem_addr_o, 32'h0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("wrap_d_pc", bus.d_pc_o, 32'hFFFF_FFFC);
        chk("wrap_d_pc4", bus.d_pc4_o, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("wrap_d_pc_next", bus.d_pc_o, 32'h0);
        chk("wrap_d_pc4_next", bus.d_pc4_o, 32'h4);

        // Reset mid-stream with a 0x400 request in flight
        do_reset(3);
        drive(0, 0, 1, 32'h400);
        next_cycle();
        drive(0, 0, 0, 32'h0);
        @(negedge clk);
        chk("mr_addr_before", bus.imem_addr_o, 32'h400);
        next_cycle();
        rst_n = 1'b0;
        #1;
        chk("mr_valid", {31'd0, bus.d_valid_o}, 32'd0);
        chk("mr_pc", bus.d_pc_o, 32'h0);
        chk("mr_instr", bus.d_instruction_o, NOP);
        chk("mr_addr", bus.imem_addr_o, 32'h100);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        chk("mr_late_rvalid", {31'd0, bus.imem_rvalid_i}, 32'd1);
        found = 0;
        for (int k = 0; k < 15 && !found; k++) begin
            @(negedge clk);
            if (bus.d_valid_o) begin
                found = 1;
                chk("mr_first_pc", bus.d_pc_o, 32'h100);
                chk("mr_first_instr", bus.d_instruction_o, 32'h100);
            end
            next_cycle();
        end
        if (!found) begin
            n_cmp++; n_fail++;
            $display("FAIL mr_timeout: no valid instruction after reset, required pc 00000100");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
